// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data stage.
// Data wins by default; a streak counter forces a fetch grant after MAX_DM_BURST data grants.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned MAX_DM_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned STREAK_W = 4;
    localparam int unsigned CNT_W    = 3;
    localparam logic [STREAK_W-1:0] BURST = STREAK_W'(MAX_DM_BURST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [STREAK_W-1:0] dm_streak;
    logic [STREAK_W-1:0] dm_streak_nxt;
    logic [CNT_W-1:0]    busy_cnt;

    // State, streak counter and cycles-since-grant counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dm_streak <= '0;
            busy_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            dm_streak <= dm_streak_nxt;
            if (state == IDLE) begin
                busy_cnt <= CNT_W'(1);
            end else begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (state != IDLE && mem_rvalid) begin
                assert (busy_cnt == CNT_W'(MEM_LATENCY))
                    else $error("mem_rvalid arrived %0d cycles after grant, expected %0d",
                                busy_cnt, MEM_LATENCY);
            end
        end
    end

    // Arbitration, request steering and response routing.
    always_comb begin
        state_nxt     = state;
        dm_streak_nxt = dm_streak;
        if_gnt        = 1'b0;
        if_rvalid     = 1'b0;
        if_rdata      = '0;
        dm_gnt        = 1'b0;
        dm_rvalid     = 1'b0;
        dm_rdata      = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_be        = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (dm_req && !(if_req && dm_streak == BURST)) begin
                        dm_gnt    = 1'b1;
                        mem_req   = 1'b1;
                        mem_we    = dm_we;
                        mem_be    = dm_be;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        state_nxt = BUSY_DM;
                        if (!if_req) begin
                            dm_streak_nxt = '0;
                        end else if (dm_streak != BURST) begin
                            dm_streak_nxt = dm_streak + STREAK_W'(1);
                        end
                    end else if (if_req) begin
                        if_gnt        = 1'b1;
                        mem_req       = 1'b1;
                        mem_be        = 4'hF;
                        mem_addr      = if_addr;
                        state_nxt     = BUSY_IF;
                        dm_streak_nxt = '0;
                    end
                end
                BUSY_IF: begin
                    if (mem_rvalid) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                        state_nxt = IDLE;
                    end
                end
                BUSY_DM: begin
                    if (mem_rvalid) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = mem_rdata;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LATENCY=1, instance 1 uses MEM_LATENCY=3.
module tb_mem_port_arbiter;
    localparam int unsigned NP   = 2;
    localparam int unsigned MAXB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        [NP];
    logic        if_req     [NP];
    logic [31:0] if_addr    [NP];
    logic        if_gnt     [NP];
    logic        if_rvalid  [NP];
    logic [31:0] if_rdata   [NP];
    logic        dm_req     [NP];
    logic        dm_we      [NP];
    logic [3:0]  dm_be      [NP];
    logic [31:0] dm_addr    [NP];
    logic [31:0] dm_wdata   [NP];
    logic        dm_gnt     [NP];
    logic        dm_rvalid  [NP];
    logic [31:0] dm_rdata   [NP];
    logic        mem_req    [NP];
    logic        mem_we     [NP];
    logic [3:0]  mem_be     [NP];
    logic [31:0] mem_addr   [NP];
    logic [31:0] mem_wdata  [NP];
    logic        mem_rvalid [NP];
    logic [31:0] mem_rdata  [NP];
    logic        stray      [NP];

    int tests = 0;
    int fails = 0;

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return (a * 32'h0100_0193) ^ 32'h1357_9BDF;
    endfunction

    function automatic int lat(input int p);
        return (p == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < NP; g++) begin : g_port
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        int          cnt   = 0;
        logic        rv    = 1'b0;
        logic [31:0] rd    = '0;
        logic [31:0] paddr = '0;

        mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_DM_BURST(MAXB)) u_dut (
            .clk(clk), .rst(rst[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_be(dm_be[g]),
            .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]), .dm_gnt(dm_gnt[g]),
            .dm_rvalid(dm_rvalid[g]), .dm_rdata(dm_rdata[g]),
            .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rvalid(mem_rvalid[g]), .mem_rdata(mem_rdata[g])
        );

        // Fixed-latency memory: answers LAT cycles after each accepted request.
        always @(posedge clk) begin
            if (mem_req[g]) begin
                cnt   <= int'(LAT) - 1;
                paddr <= mem_addr[g];
                rv    <= (LAT == 1);
                rd    <= (LAT == 1) ? mem_word(mem_addr[g]) : 32'h0;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                rv  <= (cnt == 1);
                rd  <= (cnt == 1) ? mem_word(paddr) : 32'h0;
            end else begin
                rv <= 1'b0;
                rd <= 32'h0;
            end
        end

        assign mem_rvalid[g] = rv | stray[g];
        assign mem_rdata[g]  = rd;
    end

    task automatic clear_inputs(input int p);
        if_req[p]   = 1'b0;
        if_addr[p]  = '0;
        dm_req[p]   = 1'b0;
        dm_we[p]    = 1'b0;
        dm_be[p]    = '0;
        dm_addr[p]  = '0;
        dm_wdata[p] = '0;
        stray[p]    = 1'b0;
    endtask

    task automatic drain(input int p);
        clear_inputs(p);
        repeat (lat(p) + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int p = 0; p < int'(NP); p++) begin
            rst[p] = 1'b1;  if_req[p] = 1'b1;  dm_req[p] = 1'b1;  stray[p] = 1'b1;
            if_addr[p] = 32'h40;  dm_addr[p] = 32'h80;  dm_we[p] = 1'b1;
            dm_be[p] = 4'hF;  dm_wdata[p] = 32'h1234_5678;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int p = 0; p < int'(NP); p++) begin
            tests++;
            if ({if_gnt[p], dm_gnt[p], mem_req[p], mem_we[p], if_rvalid[p], dm_rvalid[p]} !== 6'b0) begin
                fails++;
                $display("FAIL reset_ctrl[%0d]: got %b, want 000000", p,
                         {if_gnt[p], dm_gnt[p], mem_req[p], mem_we[p], if_rvalid[p], dm_rvalid[p]});
            end
            tests++;
            if ({mem_be[p], mem_addr[p], mem_wdata[p], if_rdata[p], dm_rdata[p]} !== '0) begin
                fails++;
                $display("FAIL reset_data[%0d]: addr=%h wdata=%h be=%h want all 0", p,
                         mem_addr[p], mem_wdata[p], mem_be[p]);
            end
        end
        @(negedge clk);
        for (int p = 0; p < int'(NP); p++) begin
            clear_inputs(p);
            rst[p] = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fetch_only();
        if_req[0] = 1'b1;  if_addr[0] = 32'h10;
        #1;
        tests++;
        if (!(if_gnt[0] === 1'b1 && dm_gnt[0] === 1'b0 && mem_req[0] === 1'b1 && mem_addr[0] === 32'h10
              && mem_we[0] === 1'b0 && mem_be[0] === 4'hF && mem_wdata[0] === 32'h0)) begin
            fails++;
            $display("FAIL fetch_grant: gnt=%b mem_req=%b addr=%h we=%b be=%h wdata=%h, want 1 1 10 0 f 0",
                     if_gnt[0], mem_req[0], mem_addr[0], mem_we[0], mem_be[0], mem_wdata[0]);
        end
        @(negedge clk);  #1;
        tests++;
        if (!(if_rvalid[0] === 1'b1 && if_rdata[0] === 32'h0050_0093 && if_gnt[0] === 1'b0
              && mem_req[0] === 1'b0 && dm_rvalid[0] === 1'b0)) begin
            fails++;
            $display("FAIL fetch_resp: rvalid=%b rdata=%h gnt=%b mem_req=%b, want 1 00500093 0 0",
                     if_rvalid[0], if_rdata[0], if_gnt[0], mem_req[0]);
        end
        @(negedge clk);  #1;
        tests++;
        if (if_gnt[0] !== 1'b1) begin
            fails++;
            $display("FAIL fetch_regrant: if_gnt=%b, want 1", if_gnt[0]);
        end
        drain(0);
    endtask

    task automatic test_simultaneous();
        if_req[0] = 1'b1;  if_addr[0] = 32'h20;
        dm_req[0] = 1'b1;  dm_we[0] = 1'b0;  dm_addr[0] = 32'h40;
        #1;
        tests++;
        if (!(dm_gnt[0] === 1'b1 && if_gnt[0] === 1'b0 && mem_addr[0] === 32'h40 && mem_we[0] === 1'b0)) begin
            fails++;
            $display("FAIL simul_dm_first: dm_gnt=%b if_gnt=%b addr=%h, want 1 0 40", dm_gnt[0], if_gnt[0], mem_addr[0]);
        end
        @(negedge clk);
        dm_req[0] = 1'b0;
        #1;
        tests++;
        if (!(dm_rvalid[0] === 1'b1 && dm_rdata[0] === mem_word(32'h40) && if_rvalid[0] === 1'b0
              && if_rdata[0] === 32'h0 && if_gnt[0] === 1'b0)) begin
            fails++;
            $display("FAIL simul_dm_resp: dm_rv=%b dm_rd=%h if_rv=%b if_rd=%h if_gnt=%b, want 1 %h 0 0 0",
                     dm_rvalid[0], dm_rdata[0], if_rvalid[0], if_rdata[0], if_gnt[0], mem_word(32'h40));
        end
        @(negedge clk);  #1;
        tests++;
        if (!(if_gnt[0] === 1'b1 && mem_addr[0] === 32'h20)) begin
            fails++;
            $display("FAIL simul_if_next: if_gnt=%b addr=%h, want 1 20", if_gnt[0], mem_addr[0]);
        end
        @(negedge clk);
        if_req[0] = 1'b0;
        #1;
        tests++;
        if (!(if_rvalid[0] === 1'b1 && if_rdata[0] === mem_word(32'h20) && dm_rvalid[0] === 1'b0)) begin
            fails++;
            $display("FAIL simul_if_resp: if_rv=%b if_rd=%h dm_rv=%b", if_rvalid[0], if_rdata[0], dm_rvalid[0]);
        end
        drain(0);
    endtask

    task automatic test_starvation();
        byte got[$];
        byte exp_seq[$];
        int  consec = 0;
        for (int k = 0; k < 10; k++) begin
            if (consec == int'(MAXB)) begin
                exp_seq.push_back("I");  consec = 0;
            end else begin
                exp_seq.push_back("D");  consec++;
            end
        end
        if_req[0] = 1'b1;  if_addr[0] = 32'h200;
        dm_req[0] = 1'b1;  dm_we[0] = 1'b0;  dm_addr[0] = 32'h100;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (dm_gnt[0] === 1'b1) got.push_back("D");
            if (if_gnt[0] === 1'b1) got.push_back("I");
            @(negedge clk);
        end
        tests++;
        if (got.size() != exp_seq.size()) begin
            fails++;
            $display("FAIL starve_count: %0d grants, want %0d", got.size(), exp_seq.size());
        end
        for (int k = 0; k < exp_seq.size() && k < got.size(); k++) begin
            tests++;
            if (got[k] != exp_seq[k]) begin
                fails++;
                $display("FAIL starve_order[%0d]: got %c, want %c", k, got[k], exp_seq[k]);
            end
        end
        drain(0);
    endtask

    task automatic test_store();
        dm_req[0] = 1'b1;  dm_we[0] = 1'b1;  dm_be[0] = 4'b0011;
        dm_addr[0] = 32'h80;  dm_wdata[0] = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (!(dm_gnt[0] === 1'b1 && mem_we[0] === 1'b1 && mem_be[0] === 4'b0011
              && mem_addr[0] === 32'h80 && mem_wdata[0] === 32'hDEAD_BEEF)) begin
            fails++;
            $display("FAIL store_grant: gnt=%b we=%b be=%b addr=%h wdata=%h, want 1 1 0011 80 deadbeef",
                     dm_gnt[0], mem_we[0], mem_be[0], mem_addr[0], mem_wdata[0]);
        end
        @(negedge clk);
        clear_inputs(0);
        #1;
        tests++;
        if (!(dm_rvalid[0] === 1'b1 && if_rvalid[0] === 1'b0)) begin
            fails++;
            $display("FAIL store_ack: dm_rv=%b if_rv=%b, want 1 0", dm_rvalid[0], if_rvalid[0]);
        end
        @(negedge clk);  #1;
        tests++;
        if (dm_rvalid[0] !== 1'b0 || if_rvalid[0] !== 1'b0) begin
            fails++;
            $display("FAIL store_ack_once: dm_rv=%b if_rv=%b, want 0 0", dm_rvalid[0], if_rvalid[0]);
        end
        drain(0);
    endtask

    task automatic test_stray();
        stray[0] = 1'b1;
        #1;
        tests++;
        if ({if_rvalid[0], dm_rvalid[0], if_gnt[0], dm_gnt[0], mem_req[0]} !== 5'b0) begin
            fails++;
            $display("FAIL stray_rvalid: if_rv=%b dm_rv=%b gnts=%b%b, want all 0",
                     if_rvalid[0], dm_rvalid[0], if_gnt[0], dm_gnt[0]);
        end
        @(negedge clk);
        stray[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [31:0] a;
        a = $urandom() & 32'hFFFF_FFFC;
        if_req[1] = 1'b1;  if_addr[1] = a;
        #1;
        tests++;
        if (if_gnt[1] !== 1'b1 || mem_addr[1] !== a) begin
            fails++;
            $display("FAIL lat_grant: if_gnt=%b addr=%h, want 1 %h", if_gnt[1], mem_addr[1], a);
        end
        @(negedge clk);
        if_req[1] = 1'b0;
        dm_req[1] = 1'b1;  dm_we[1] = 1'b0;  dm_addr[1] = 32'h300;
        for (int c = 1; c < 3; c++) begin
            #1;
            tests++;
            if ({if_gnt[1], dm_gnt[1], mem_req[1], if_rvalid[1], dm_rvalid[1]} !== 5'b0) begin
                fails++;
                $display("FAIL lat_busy[%0d]: gnt=%b%b mem_req=%b rv=%b%b, want all 0", c,
                         if_gnt[1], dm_gnt[1], mem_req[1], if_rvalid[1], dm_rvalid[1]);
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (!(if_rvalid[1] === 1'b1 && if_rdata[1] === mem_word(a) && dm_gnt[1] === 1'b0)) begin
            fails++;
            $display("FAIL lat_resp: if_rv=%b if_rd=%h dm_gnt=%b, want 1 %h 0",
                     if_rvalid[1], if_rdata[1], dm_gnt[1], mem_word(a));
        end
        @(negedge clk);  #1;
        tests++;
        if (dm_gnt[1] !== 1'b1 || mem_addr[1] !== 32'h300) begin
            fails++;
            $display("FAIL lat_next: dm_gnt=%b addr=%h, want 1 300", dm_gnt[1], mem_addr[1]);
        end
        drain(1);
    endtask

    task automatic test_reset_busy();
        dm_req[1] = 1'b1;  dm_we[1] = 1'b0;  dm_addr[1] = 32'h44;
        #1;
        tests++;
        if (dm_gnt[1] !== 1'b1) begin
            fails++;
            $display("FAIL rstbusy_grant: dm_gnt=%b, want 1", dm_gnt[1]);
        end
        @(negedge clk);
        dm_req[1] = 1'b0;
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        tests++;
        if (dm_rvalid[1] !== 1'b0 || if_rvalid[1] !== 1'b0) begin
            fails++;
            $display("FAIL rstbusy_idle: dm_rv=%b if_rv=%b, want 0 0", dm_rvalid[1], if_rvalid[1]);
        end
        @(negedge clk);
        if_req[1] = 1'b1;  if_addr[1] = 32'h500;
        #1;
        tests++;
        if (!(dm_rvalid[1] === 1'b0 && if_rvalid[1] === 1'b0 && if_gnt[1] === 1'b1 && mem_addr[1] === 32'h500)) begin
            fails++;
            $display("FAIL rstbusy_late: dm_rv=%b if_rv=%b if_gnt=%b addr=%h, want 0 0 1 500",
                     dm_rvalid[1], if_rvalid[1], if_gnt[1], mem_addr[1]);
        end
        drain(1);
    endtask

    // Random traffic against a transaction-level model of the arbitration rules.
    task automatic test_random(input int p, input int ncyc);
        bit          ifp = 0, dmp = 0, if_wait = 0, dm_wait = 0, busy = 0, busy_now;
        bit          exp_if, exp_dm, exp_ifrv, exp_dmrv;
        int          owner = 0, resp_cyc = 0, consec = 0;
        logic [31:0] taddr = '0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if_req[p] = ifp;
            dm_req[p] = dmp;
            if (!ifp && !if_wait && $urandom_range(0, 2) == 0) begin
                ifp = 1;  if_req[p] = 1'b1;  if_addr[p] = $urandom() & 32'hFFFF_FFFC;
            end
            if (!dmp && !dm_wait && $urandom_range(0, 1) == 0) begin
                dmp = 1;  dm_req[p] = 1'b1;  dm_we[p] = 1'($urandom_range(0, 1));
                dm_be[p] = 4'($urandom_range(1, 15));
                dm_addr[p] = $urandom();  dm_wdata[p] = $urandom();
            end
            #1;
            busy_now = busy;
            exp_ifrv = busy_now && cyc == resp_cyc && owner == 0;
            exp_dmrv = busy_now && cyc == resp_cyc && owner == 1;
            tests++;
            if (!(if_rvalid[p] === exp_ifrv && dm_rvalid[p] === exp_dmrv
                  && if_rdata[p] === (exp_ifrv ? mem_word(taddr) : 32'h0)
                  && dm_rdata[p] === (exp_dmrv ? mem_word(taddr) : 32'h0))) begin
                fails++;
                $display("FAIL rand%0d_resp c%0d: rv=%b%b rd=%h/%h, want %b%b %h", p, cyc,
                         if_rvalid[p], dm_rvalid[p], if_rdata[p], dm_rdata[p], exp_ifrv, exp_dmrv, mem_word(taddr));
            end
            if (exp_ifrv) begin busy = 0; if_wait = 0; end
            if (exp_dmrv) begin busy = 0; dm_wait = 0; end
            exp_dm = !busy_now && dmp && !(ifp && consec == int'(MAXB));
            exp_if = !busy_now && !exp_dm && ifp;
            tests++;
            if ({if_gnt[p], dm_gnt[p], mem_req[p]} !== {exp_if, exp_dm, exp_if | exp_dm}) begin
                fails++;
                $display("FAIL rand%0d_gnt c%0d: if/dm/mem=%b%b%b, want %b%b%b", p, cyc,
                         if_gnt[p], dm_gnt[p], mem_req[p], exp_if, exp_dm, exp_if | exp_dm);
            end
            tests++;
            if (exp_dm) begin
                if ({mem_we[p], mem_be[p], mem_addr[p], mem_wdata[p]} !== {dm_we[p], dm_be[p], dm_addr[p], dm_wdata[p]}) begin
                    fails++;
                    $display("FAIL rand%0d_dm_payload c%0d: addr=%h want %h", p, cyc, mem_addr[p], dm_addr[p]);
                end
                consec = ifp ? ((consec < int'(MAXB)) ? consec + 1 : consec) : 0;
                busy = 1;  owner = 1;  taddr = dm_addr[p];  resp_cyc = cyc + lat(p);
                dmp = 0;  dm_wait = 1;
            end else if (exp_if) begin
                if ({mem_we[p], mem_be[p], mem_addr[p], mem_wdata[p]} !== {1'b0, 4'hF, if_addr[p], 32'h0}) begin
                    fails++;
                    $display("FAIL rand%0d_if_payload c%0d: addr=%h want %h", p, cyc, mem_addr[p], if_addr[p]);
                end
                consec = 0;
                busy = 1;  owner = 0;  taddr = if_addr[p];  resp_cyc = cyc + lat(p);
                ifp = 0;  if_wait = 1;
            end else if ({mem_we[p], mem_be[p], mem_addr[p], mem_wdata[p]} !== '0) begin
                fails++;
                $display("FAIL rand%0d_idle_payload c%0d: addr=%h be=%h, want 0", p, cyc, mem_addr[p], mem_be[p]);
            end
        end
        drain(p);
    endtask

    initial begin
        for (int p = 0; p < int'(NP); p++) begin
            rst[p] = 1'b1;
            clear_inputs(p);
        end
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_store();
        test_stray();
        test_latency();
        test_reset_busy();
        test_random(0, 400);
        test_random(1, 400);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
